huffman_stream_ctrl: RTL and testbench
======================================

Name: huffman_stream_ctrl

Overview:
- Sequencer for the Huffman coder datapath: accepts 8-bit symbols over a valid/ready handshake and issues one code-table lookup per symbol.
- Appends each returned variable-length code to a bit accumulator and emits packed bytes MSB-first over a valid/ready output.
- Sits between the tt_um_huffman_coder pin interface (ui_in/uo_out) and the code table; also services an explicit flush that pads the final partial byte.

Parameters:
MAX_LEN, 12, maximum code length in bits (legal range 1..16)
LEN_W, 4, width of the lut_len field (must hold MAX_LEN; 4 bits covers 1..15, use 5 for 16)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
sym_valid  input  1  input symbol valid
sym_ready  output  1  controller can accept a symbol
sym_data  input  8  symbol value
flush  input  1  single-cycle pulse: pad and emit residual bits
lut_req  output  1  lookup request, held until lut_ack
lut_sym  output  8  symbol presented to table, stable while lut_req=1
lut_ack  input  1  table response valid (single cycle)
lut_code  input  MAX_LEN  code, right-aligned; bit lut_len-1 is sent first
lut_len  input  LEN_W  code length in bits
out_valid  output  1  out_byte valid
out_ready  input  1  consumer accepts out_byte
out_byte  output  8  packed output byte
flush_done  output  1  one-cycle pulse when a flush completes
err  output  1  one-cycle pulse on an illegal lut_len
busy  output  1  high in any state except IDLE, or while a flush is pending

Behaviour:
- Reset (rst=1 at a clock edge, synchronous): state=IDLE; accumulator and residual count cnt cleared; flush_pend=0.
  - Outputs: lut_req=0, lut_sym=0, out_valid=0, out_byte=0, flush_done=0, err=0, busy=0.
  - sym_ready is decoded from state: 1 in IDLE, and 0 while rst=1.
  - Reset mid-operation discards all buffered bits and any pending flush.
- Accumulator width: MAX_LEN+7 bits. cnt range 0..MAX_LEN+7. Bits are packed MSB-first.
- States:
  - IDLE:
    - sym_ready = !flush_pend.
    - sym_valid & sym_ready: latch sym_data into lut_sym, go to LOOKUP.
    - Otherwise, if flush_pend: go to FLUSH.
  - LOOKUP:
    - lut_req=1 until lut_ack is seen.
    - On lut_ack with 1 <= lut_len <= MAX_LEN: shift the low lut_len bits of lut_code in below the current residual, cnt += lut_len, go to DRAIN.
    - On lut_ack with lut_len=0 or lut_len>MAX_LEN: err pulses the next cycle, symbol is dropped, accumulator is unchanged, go to IDLE.
  - DRAIN:
    - If cnt>=8: out_byte = top 8 valid bits, out_valid=1.
    - On out_valid & out_ready: cnt -= 8, remaining bits are left-justified.
    - When cnt<8: go to IDLE.
  - FLUSH:
    - If cnt>0: out_byte = residual bits followed by zero padding, out_valid=1 until accepted; then cnt=0.
    - Then flush_done pulses for 1 cycle, flush_pend clears, go to IDLE.
    - Flush with cnt=0 emits no byte; flush_done pulses the cycle after entering FLUSH.
- flush may arrive in any state and is latched into flush_pend. It is serviced only from IDLE, after any symbol accepted in the same cycle has been fully drained. A second flush pulse while flush_pend=1 is absorbed (single completion).
- out_byte must stay stable while out_valid=1 and out_ready=0. out_valid never drops without acceptance except on reset.
- Minimum latency, symbol accept to first out_valid: 2 cycles plus table latency (LOOKUP entry, ack, DRAIN).
- A new symbol is accepted only in IDLE. Throughput is at most 1 symbol per lookup+drain sequence (no overlap).

Optional Feature:
- Macro: HUFFMAN_STATS_EN.
- Defined:
  - Adds output ports sym_count[15:0] (symbols accepted with legal length) and byte_count[15:0] (bytes handed off, including flush bytes), plus input stats_clr.
  - Both counters wrap modulo 2^16 and clear on rst or stats_clr. stats_clr wins over a same-cycle increment.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles while sym_valid=1 and flush=1 -> all outputs 0, sym_ready=0 during reset, sym_ready=1 the first cycle after release, no flush_done.
- Packing: sym 0x41 -> table code 3'b101 len 3, then sym 0x42 -> code 5'b11100 len 5 -> exactly one out_byte=0xBC, cnt=0 afterwards.
- Flush: sym -> code 3'b101 len 3, then flush pulse -> out_byte=0xA0, then flush_done=1 for one cycle; a second flush with cnt=0 -> flush_done only, no out_valid.
- Max length: code 12'hABC len 12 -> out_byte=0xAB, cnt=4; flush -> out_byte=0xC0.
- Backpressure: out_ready=0 for 5 cycles during DRAIN -> out_valid stays 1, out_byte stable, sym_ready=0, lut_req=0; accepted on the first out_ready=1.
- Error and stats: lut_len=0, then lut_len=13 -> err pulses twice, no out_valid; with HUFFMAN_STATS_EN the packing case gives sym_count=2, byte_count=1, and stats_clr returns both to 0.

Source files
------------

// File: rtl/huffman_stream_ctrl.sv
// huffman_stream_ctrl: symbol -> code-table lookup -> MSB-first byte packer with explicit flush.
// Defining HUFFMAN_STATS_EN adds stats_clr, sym_count and byte_count.
module huffman_stream_ctrl #(
    parameter int MAX_LEN = 12,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [7:0]         sym_data,
    input  logic               flush,
    output logic               lut_req,
    output logic [7:0]         lut_sym,
    input  logic               lut_ack,
    input  logic [MAX_LEN-1:0] lut_code,
    input  logic [LEN_W-1:0]   lut_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               flush_done,
    output logic               err,
    output logic               busy
`ifdef HUFFMAN_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [15:0]        sym_count,
    output logic [15:0]        byte_count
`endif
);
    localparam int ACC_W = MAX_LEN + 7;
    localparam int CNT_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, DRAIN, FLUSH} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_ins;
    logic [CNT_W-1:0]   cnt, shamt;
    logic [MAX_LEN-1:0] code_mask;
    logic               flush_pend;
    logic               len_ok, accept, pop, flush_fin;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sym_ready = 1'b0;
        lut_req   = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        pop       = 1'b0;
        flush_fin = 1'b0;
        case (state)
            IDLE: begin
                sym_ready = !flush_pend && !rst;
                if (sym_valid && sym_ready) begin
                    accept    = 1'b1;
                    state_nxt = LOOKUP;
                end else if (flush_pend) begin
                    state_nxt = FLUSH;
                end
            end
            LOOKUP: begin
                lut_req = 1'b1;
                if (lut_ack)
                    state_nxt = len_ok ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (cnt >= CNT_W'(8)) begin
                    out_valid = 1'b1;
                    pop       = out_ready;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                // Residual is always under 8 bits here; the zero tail of acc is the padding.
                if (cnt != '0) begin
                    out_valid = 1'b1;
                    pop       = out_ready;
                end else begin
                    flush_fin = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Valid bits sit left-justified in acc; new code bits land directly below the residual.
    assign len_ok    = (lut_len != '0) && (int'(lut_len) <= MAX_LEN);
    assign code_mask = (MAX_LEN'(1) << lut_len) - MAX_LEN'(1);
    assign shamt     = CNT_W'(ACC_W) - cnt - CNT_W'(lut_len);
    assign acc_ins   = ACC_W'(lut_code & code_mask) << shamt;

    assign out_byte  = out_valid ? acc[ACC_W-1 -: 8] : 8'd0;
    assign busy      = (state != IDLE) || flush_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            lut_sym    <= 8'd0;
            err        <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            err        <= 1'b0;
            flush_done <= flush_fin;
            if (accept)
                lut_sym <= sym_data;
            if (state == LOOKUP && lut_ack) begin
                if (len_ok) begin
                    acc <= acc | acc_ins;
                    cnt <= cnt + CNT_W'(lut_len);
                end else begin
                    err <= 1'b1;
                end
            end
            if (pop) begin
                acc <= acc << 8;
                cnt <= (state == FLUSH) ? '0 : cnt - CNT_W'(8);
            end
            if (flush_fin)
                flush_pend <= 1'b0;
            else if (flush)
                flush_pend <= 1'b1;
        end
    end

`ifdef HUFFMAN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            sym_count  <= 16'd0;
            byte_count <= 16'd0;
        end else begin
            if (state == LOOKUP && lut_ack && len_ok)
                sym_count <= sym_count + 16'd1;
            if (pop)
                byte_count <= byte_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_huffman_stream_ctrl.sv
// Self-checking bench for huffman_stream_ctrl: directed scenarios plus a randomized run,
// all checked against a bit-queue packing model and a scripted code table.
module tb_huffman_stream_ctrl;
    localparam int MAX_LEN = 12;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               sym_valid;
    logic               sym_ready;
    logic [7:0]         sym_data;
    logic               flush;
    logic               lut_req;
    logic [7:0]         lut_sym;
    logic               lut_ack;
    logic [MAX_LEN-1:0] lut_code;
    logic [LEN_W-1:0]   lut_len;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_byte;
    logic               flush_done;
    logic               err;
    logic               busy;
`ifdef HUFFMAN_STATS_EN
    logic               stats_clr;
    logic [15:0]        sym_count;
    logic [15:0]        byte_count;
`endif

    huffman_stream_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
        .flush(flush),
        .lut_req(lut_req), .lut_sym(lut_sym), .lut_ack(lut_ack),
        .lut_code(lut_code), .lut_len(lut_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .flush_done(flush_done), .err(err), .busy(busy)
`ifdef HUFFMAN_STATS_EN
        , .stats_clr(stats_clr), .sym_count(sym_count), .byte_count(byte_count)
`endif
    );

    always #5 clk = ~clk;

    int pass_count  = 0;
    int total_count = 0;

    logic [MAX_LEN-1:0] tab_code [256];
    logic [LEN_W-1:0]   tab_len  [256];

    bit         bit_q[$];
    logic [7:0] exp_q[$];
    int         exp_err = 0, seen_err = 0;
    int         exp_fd = 0, seen_fd = 0;
    int         model_syms = 0, model_bytes = 0;
    int         lat_left = 0;
    bit         err_due = 1'b0;
    int         ready_mode = 1;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_byte = 8'd0;
    logic [7:0] last_byte = 8'd0;
    logic [7:0] cur_sym = 8'd0;
    int         bytes_seen = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    function automatic bit legal_len(input logic [LEN_W-1:0] l);
        return (l != '0) && (int'(l) <= MAX_LEN);
    endfunction

    task automatic model_pop_bytes();
        logic [7:0] b;
        while (bit_q.size() >= 8) begin
            b = 8'd0;
            for (int k = 0; k < 8; k++)
                b = {b[6:0], bit_q.pop_front()};
            exp_q.push_back(b);
            model_bytes++;
        end
    endtask

    task automatic model_accept(input logic [7:0] s);
        logic [MAX_LEN-1:0] c;
        int l;
        c = tab_code[s];
        l = int'(tab_len[s]);
        cur_sym = s;
        if (!legal_len(tab_len[s])) begin
            exp_err++;
            return;
        end
        model_syms++;
        for (int i = l - 1; i >= 0; i--)
            bit_q.push_back(c[i]);
        model_pop_bytes();
    endtask

    task automatic model_flush();
        if (bit_q.size() > 0) begin
            while (bit_q.size() < 8)
                bit_q.push_back(1'b0);
            model_pop_bytes();
        end
        exp_fd++;
    endtask

    // One clock: sample #1 after the edge, act as code table and byte consumer, check timing rules.
    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput("err_timing", 32'(err), 32'(err_due));
        err_due = 1'b0;
        if (err) seen_err++;
        if (flush_done) seen_fd++;
        if (prev_valid && !prev_ready) begin
            checkOutput("hold_valid", 32'(out_valid), 1);
            checkOutput("hold_byte", 32'(out_byte), 32'(prev_byte));
        end
        lut_ack  = 1'b0;
        lut_code = MAX_LEN'($urandom);
        lut_len  = LEN_W'($urandom);
        if (lut_req) begin
            if (lat_left == 0) begin
                checkOutput("lut_sym", 32'(lut_sym), 32'(cur_sym));
                lut_ack  = 1'b1;
                lut_code = tab_code[cur_sym];
                lut_len  = tab_len[cur_sym];
                err_due  = !legal_len(tab_len[cur_sym]);
                lat_left = $urandom_range(0, 3);
            end else begin
                lat_left--;
            end
        end
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 99) < 70);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
                checkOutput("unexpected_byte", 1, 0);
            else
                checkOutput("out_byte", 32'(out_byte), 32'(exp_q.pop_front()));
            last_byte = out_byte;
            bytes_seen++;
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_byte  = out_byte;
    endtask

    task automatic applyStimulus(input logic [7:0] s, input bit with_flush);
        int budget;
        budget = 500;
        while (!sym_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!sym_ready) begin
            checkOutput("sym_ready_timeout", 0, 1);
            return;
        end
        sym_valid = 1'b1;
        sym_data  = s;
        model_accept(s);
        if (with_flush) begin
            flush = 1'b1;
            model_flush();
        end
        tick();
        sym_valid = 1'b0;
        flush     = 1'b0;
        sym_data  = 8'($urandom);
    endtask

    task automatic send_flush();
        flush = 1'b1;
        model_flush();
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 500;
        while ((busy || !sym_ready) && budget > 0) begin
            tick();
            budget--;
        end
        if (busy)
            checkOutput("idle_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bb, fb, eb;
        for (int i = 0; i < 256; i++) begin
            tab_code[i] = MAX_LEN'($urandom);
            tab_len[i]  = LEN_W'($urandom_range(1, MAX_LEN));
        end
        tab_code[8'h41] = 12'h005; tab_len[8'h41] = 4'd3;
        tab_code[8'h42] = 12'h01C; tab_len[8'h42] = 4'd5;
        tab_code[8'h5A] = 12'hABC; tab_len[8'h5A] = 4'd12;
        tab_code[8'h66] = 12'h0A5; tab_len[8'h66] = 4'd8;
        tab_code[8'h10] = 12'hFFF; tab_len[8'h10] = 4'd0;
        tab_code[8'h11] = 12'hFFF; tab_len[8'h11] = 4'd13;

        // Reset held two cycles with sym_valid and flush asserted.
        rst = 1'b1; sym_valid = 1'b1; sym_data = 8'h55; flush = 1'b1;
        out_ready = 1'b0; lut_ack = 1'b0; lut_code = '0; lut_len = '0;
`ifdef HUFFMAN_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("rst_sym_ready", 32'(sym_ready), 0);
            checkOutput("rst_out_valid", 32'(out_valid), 0);
            checkOutput("rst_out_byte", 32'(out_byte), 0);
            checkOutput("rst_lut_req", 32'(lut_req), 0);
            checkOutput("rst_lut_sym", 32'(lut_sym), 0);
            checkOutput("rst_flush_done", 32'(flush_done), 0);
            checkOutput("rst_err", 32'(err), 0);
            checkOutput("rst_busy", 32'(busy), 0);
        end
        rst = 1'b0; sym_valid = 1'b0; flush = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'(sym_ready), 1);
        repeat (3) tick();
        checkOutput("no_flush_after_reset", 32'(seen_fd), 0);

        // Packing two short codes into one byte.
        ready_mode = 1;
        bb = bytes_seen;
        applyStimulus(8'h41, 1'b0); wait_idle();
        applyStimulus(8'h42, 1'b0); wait_idle();
        checkOutput("pack_count", 32'(bytes_seen - bb), 1);
        checkOutput("pack_byte", 32'(last_byte), 32'h BC);
`ifdef HUFFMAN_STATS_EN
        checkOutput("stats_sym", 32'(sym_count), 2);
        checkOutput("stats_byte", 32'(byte_count), 1);
        stats_clr = 1'b1; tick(); stats_clr = 1'b0;
        model_syms = 0; model_bytes = 0;
        checkOutput("stats_clr_sym", 32'(sym_count), 0);
        checkOutput("stats_clr_byte", 32'(byte_count), 0);
`endif
        send_flush(); wait_idle();
        checkOutput("pack_no_residual", 32'(bytes_seen - bb), 1);

        // Flush of a 3-bit residual, then an empty flush with exact pulse timing.
        applyStimulus(8'h41, 1'b0); wait_idle();
        bb = bytes_seen; fb = seen_fd;
        send_flush(); wait_idle();
        checkOutput("flush_byte", 32'(last_byte), 32'h A0);
        checkOutput("flush_count", 32'(bytes_seen - bb), 1);
        checkOutput("flush_done_once", 32'(seen_fd - fb), 1);
        bb = bytes_seen;
        send_flush();
        tick(); checkOutput("empty_flush_early", 32'(flush_done), 0);
        tick(); checkOutput("empty_flush_pulse", 32'(flush_done), 1);
        tick(); checkOutput("empty_flush_end", 32'(flush_done), 0);
        checkOutput("empty_flush_nobyte", 32'(bytes_seen - bb), 0);

        // Maximum-length code and its 4-bit residual.
        bb = bytes_seen;
        applyStimulus(8'h5A, 1'b0); wait_idle();
        checkOutput("maxlen_byte", 32'(last_byte), 32'h AB);
        checkOutput("maxlen_count", 32'(bytes_seen - bb), 1);
        send_flush(); wait_idle();
        checkOutput("maxlen_flush_byte", 32'(last_byte), 32'h C0);

        // Backpressure during DRAIN.
        ready_mode = 2;
        bb = bytes_seen;
        applyStimulus(8'h66, 1'b0);
        for (int i = 0; i < 30 && !out_valid; i++) tick();
        checkOutput("bp_valid", 32'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_hold_valid", 32'(out_valid), 1);
            checkOutput("bp_hold_byte", 32'(out_byte), 32'h A5);
            checkOutput("bp_sym_ready", 32'(sym_ready), 0);
            checkOutput("bp_lut_req", 32'(lut_req), 0);
        end
        ready_mode = 1;
        tick();
        checkOutput("bp_accept_first", 32'(bytes_seen - bb), 1);
        wait_idle();

        // Illegal lengths 0 and 13.
        bb = bytes_seen; eb = seen_err;
        applyStimulus(8'h10, 1'b0); wait_idle();
        applyStimulus(8'h11, 1'b0); wait_idle();
        checkOutput("err_count", 32'(seen_err - eb), 2);
        checkOutput("err_nobyte", 32'(bytes_seen - bb), 0);

        // Second flush while one is pending is absorbed.
        applyStimulus(8'h41, 1'b0); wait_idle();
        bb = bytes_seen; fb = seen_fd;
        flush = 1'b1; model_flush(); tick();
        flush = 1'b1; tick();
        flush = 1'b0;
        wait_idle(); repeat (4) tick();
        checkOutput("absorb_done", 32'(seen_fd - fb), 1);
        checkOutput("absorb_byte", 32'(last_byte), 32'h A0);
        checkOutput("absorb_count", 32'(bytes_seen - bb), 1);

        // Randomized run with random table, latency, backpressure and flushes.
        for (int i = 0; i < 256; i++) begin
            tab_code[i] = MAX_LEN'($urandom);
            if ($urandom_range(0, 15) == 0)
                tab_len[i] = ($urandom_range(0, 1) == 0) ? 4'd0 : LEN_W'($urandom_range(13, 15));
            else
                tab_len[i] = LEN_W'($urandom_range(1, MAX_LEN));
        end
        ready_mode = 0;
        for (int n = 0; n < 200; n++) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0) begin
                wait_idle();
                send_flush();
            end
        end
        wait_idle();
        send_flush();
        wait_idle();
        repeat (5) tick();
        checkOutput("final_leftover", 32'(exp_q.size()), 0);
        checkOutput("final_err_total", 32'(seen_err), 32'(exp_err));
        checkOutput("final_flush_total", 32'(seen_fd), 32'(exp_fd));
`ifdef HUFFMAN_STATS_EN
        checkOutput("final_stats_sym", 32'(sym_count), 32'(model_syms % 65536));
        checkOutput("final_stats_byte", 32'(byte_count), 32'(model_bytes % 65536));
`endif

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
